// File: rtl/garage_light_ctrl.sv
// Garage stop indicator: debounces the sensor zone code and sequences the
// Green/Yellow/Red lamps plus a flashing Stop lamp. Define GARAGE_PARK_TIMEOUT_EN
// to add the timeout from STOP into the dark PARKED state.
module garage_light_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FLASH_HALF      = 8,
  parameter int unsigned PARK_CYCLES     = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] C_i,
  output logic       Green_o,
  output logic       Yellow_o,
  output logic       Red_o,
  output logic       Stop_o,
  output logic       Parked_o
);

  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);

`ifdef GARAGE_PARK_TIMEOUT_EN
  localparam int unsigned        PARK_W    = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
  localparam logic [PARK_W-1:0]  PARK_LAST = PARK_W'(PARK_CYCLES - 1);
`endif

  // Parameter sanity check at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || FLASH_HALF < 1 || PARK_CYCLES < 1) begin : g_param_check
    $error("garage_light_ctrl: DEBOUNCE_CYCLES, FLASH_HALF and PARK_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_FAR    = 3'd0,
    S_NEAR   = 3'd1,
    S_CLOSE  = 3'd2,
    S_STOP   = 3'd3,
    S_PARKED = 3'd4
  } state_t;

  // Zone code represented by each state; PARKED shares the STOP code.
  function automatic logic [1:0] zone_of(input state_t s);
    logic [1:0] z;
    case (s)
      S_NEAR:           z = 2'b01;
      S_CLOSE:          z = 2'b10;
      S_STOP, S_PARKED: z = 2'b11;
      default:          z = 2'b00;
    endcase
    return z;
  endfunction

  function automatic state_t state_of(input logic [1:0] z);
    state_t s;
    case (z)
      2'b00:   s = S_FAR;
      2'b01:   s = S_NEAR;
      2'b10:   s = S_CLOSE;
      default: s = S_STOP;
    endcase
    return s;
  endfunction

  logic [1:0]         c_q;
  logic [1:0]         cand_q, cand_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               qualify_c;
  state_t             state_q, state_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               phase_q, phase_d;
`ifdef GARAGE_PARK_TIMEOUT_EN
  logic [PARK_W-1:0]  park_cnt_q, park_cnt_d;
`endif

  // Register bank: sampler, debouncer, FSM state, flash/park counters, lamps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_q         <= 2'b00;
      cand_q      <= 2'b00;
      deb_cnt_q   <= '0;
      state_q     <= S_FAR;
      flash_cnt_q <= '0;
      phase_q     <= 1'b0;
      Green_o     <= 1'b1;
      Yellow_o    <= 1'b0;
      Red_o       <= 1'b0;
      Stop_o      <= 1'b0;
`ifdef GARAGE_PARK_TIMEOUT_EN
      park_cnt_q  <= '0;
      Parked_o    <= 1'b0;
`endif
    end else begin
      c_q         <= C_i;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
      Green_o     <= (state_d == S_FAR);
      Yellow_o    <= (state_d == S_NEAR);
      Red_o       <= (state_d == S_CLOSE) || (state_d == S_STOP);
      Stop_o      <= (state_d == S_STOP) && phase_d;
`ifdef GARAGE_PARK_TIMEOUT_EN
      park_cnt_q  <= park_cnt_d;
      Parked_o    <= (state_d == S_PARKED);
`endif
    end
  end

`ifndef GARAGE_PARK_TIMEOUT_EN
  assign Parked_o = 1'b0;
`endif

  // Debounce, zone FSM next state, and STOP flash/park counters.
  always_comb begin
    cand_d      = cand_q;
    deb_cnt_d   = deb_cnt_q;
    qualify_c   = 1'b0;
    state_d     = state_q;
    flash_cnt_d = '0;
    phase_d     = 1'b0;
`ifdef GARAGE_PARK_TIMEOUT_EN
    park_cnt_d  = '0;
`endif

    if (c_q != cand_q) begin
      cand_d    = c_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      qualify_c = 1'b1;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end

    // A qualified zone change takes priority over the park timeout.
    if (qualify_c && (cand_q != zone_of(state_q))) begin
      state_d = state_of(cand_q);
    end
`ifdef GARAGE_PARK_TIMEOUT_EN
    else if ((state_q == S_STOP) && (park_cnt_q == PARK_LAST)) begin
      state_d = S_PARKED;
    end
`endif

    if (state_d == S_STOP) begin
      if (state_q != S_STOP) begin
        phase_d = 1'b1;
      end else begin
        if (flash_cnt_q == FLASH_LAST) begin
          flash_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          flash_cnt_d = flash_cnt_q + FLASH_W'(1);
          phase_d     = phase_q;
        end
`ifdef GARAGE_PARK_TIMEOUT_EN
        park_cnt_d = park_cnt_q + PARK_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_garage_light_ctrl.sv
// Directed bench for garage_light_ctrl: vector table for debounce/zone
// sequencing plus hand sequences for flash timing, park timeout and reset.
module tb_garage_light_ctrl;

  localparam logic [4:0] L_FAR      = 5'b10000;
  localparam logic [4:0] L_NEAR     = 5'b01000;
  localparam logic [4:0] L_CLOSE    = 5'b00100;
  localparam logic [4:0] L_STOP_ON  = 5'b00110;
  localparam logic [4:0] L_STOP_OFF = 5'b00100;
  localparam logic [4:0] L_PARK     = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] C_i = 2'b00;
  logic       Green_o, Yellow_o, Red_o, Stop_o, Parked_o;
  logic [4:0] lamps;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [1:0] c;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  garage_light_ctrl dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .C_i     (C_i),
    .Green_o (Green_o),
    .Yellow_o(Yellow_o),
    .Red_o   (Red_o),
    .Stop_o  (Stop_o),
    .Parked_o(Parked_o)
  );

  always #5 clk = ~clk;

  assign lamps = {Green_o, Yellow_o, Red_o, Stop_o, Parked_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    checks++;
    if (lamps !== exp) begin
      errors++;
      $display("FAIL %s lamps(GYRSP) got=%b expected=%b at %0t", name, lamps, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic [1:0] c, input logic [4:0] e);
    vec_t v;
    v.rst = r;
    v.c   = c;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Stable zone for DEBOUNCE+2 edges: unchanged for five, new lamps on the sixth.
  task automatic add_qual(input logic [1:0] c, input logic [4:0] hold, input logic [4:0] fin);
    for (int i = 0; i < 5; i++) add_vec(1'b0, c, hold);
    add_vec(1'b0, c, fin);
  endtask

  // From a quiet state, drive STOP and check entry on the sixth edge.
  task automatic enter_stop(input string name, input logic [4:0] hold);
    rst_i = 1'b0;
    C_i   = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      check({name, "_hold"}, hold);
    end
    tick();
    check({name, "_entry"}, L_STOP_ON);
  endtask

  initial begin
    // Reset with C_i=11, then stable STOP entry at E0+5
    add_vec(1'b1, 2'b11, L_FAR);
    add_vec(1'b1, 2'b11, L_FAR);
    add_qual(2'b11, L_FAR, L_STOP_ON);
    // Back to FAR via reset
    add_vec(1'b1, 2'b00, L_FAR);
    add_vec(1'b0, 2'b00, L_FAR);
    // 3-cycle NEAR glitch must be ignored
    for (int i = 0; i < 3; i++) add_vec(1'b0, 2'b01, L_FAR);
    for (int i = 0; i < 6; i++) add_vec(1'b0, 2'b00, L_FAR);
    // Held NEAR qualifies, then CLOSE, then straight back to FAR
    add_qual(2'b01, L_FAR, L_NEAR);
    add_qual(2'b10, L_NEAR, L_CLOSE);
    add_qual(2'b00, L_CLOSE, L_FAR);
    // NEAR -> STOP jump, then STOP -> NEAR exit drops flashing lamp
    add_qual(2'b01, L_FAR, L_NEAR);
    add_qual(2'b11, L_NEAR, L_STOP_ON);
    add_qual(2'b01, L_STOP_ON, L_NEAR);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_i = vecs[i].rst;
      C_i   = vecs[i].c;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Flash timing from a fresh STOP entry
    rst_i = 1'b1;
    C_i   = 2'b00;
    tick();
    check("flash_reset", L_FAR);
    enter_stop("flash", L_FAR);
`ifdef GARAGE_PARK_TIMEOUT_EN
    for (int k = 1; k < 64; k++) begin
      tick();
      check($sformatf("flash_k%0d", k), ((k / 8) % 2 == 0) ? L_STOP_ON : L_STOP_OFF);
    end
    tick();
    check("park_timeout", L_PARK);

    // Glitch to 00 then re-qualified 11 keeps PARKED
    C_i = 2'b00;
    tick();
    check("park_glitch0", L_PARK);
    tick();
    check("park_glitch1", L_PARK);
    C_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("park_hold%0d", i), L_PARK);
    end

    // Exit from PARKED straight to CLOSE
    C_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("park_exit_hold", L_PARK);
    end
    tick();
    check("park_exit_close", L_CLOSE);

    // Zone change qualifying on the timeout edge wins over PARKED
    enter_stop("race", L_CLOSE);
    for (int k = 1; k <= 58; k++) tick();
    C_i = 2'b10;
    for (int k = 59; k < 64; k++) tick();
    check("race_pre", L_STOP_OFF);
    tick();
    check("race_timeout_edge", L_CLOSE);
    enter_stop("race_reenter", L_CLOSE);
`else
    for (int k = 1; k <= 200; k++) begin
      tick();
      check($sformatf("flash_k%0d", k), ((k / 8) % 2 == 0) ? L_STOP_ON : L_STOP_OFF);
    end
`endif

    // Reset mid-flash, then re-entry six edges after release
    C_i = 2'b11;
    if (lamps !== L_STOP_ON) begin
      C_i = 2'b00;
      rst_i = 1'b1;
      tick();
      enter_stop("pre_rst", L_FAR);
    end
    check("rst_flash_on", L_STOP_ON);
    rst_i = 1'b1;
    tick();
    check("rst_mid_flash", L_FAR);
    enter_stop("rst_reenter", L_FAR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
